// File: rtl/chipscope_burst_strobe.sv
// Enable-strobe generator for the toggle test stage: synchronises and debounces a push-button,
// then emits a burst of burst_len single-cycle pulses spaced period clocks apart per press.
module chipscope_burst_strobe #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PERIOD_W        = 16,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] period,
    input  logic [COUNT_W-1:0]  burst_len,
    output logic                pulse,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  pulse_count
);

    localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic              s1;
    logic              s2;
    logic              deb;
    logic              deb_d;
    logic [DCNT_W-1:0] deb_cnt;
    logic              trig;

    state_t            state;
    state_t            state_n;
    logic [PERIOD_W-1:0] ival;
    logic [PERIOD_W-1:0] ival_n;
    logic [PERIOD_W-1:0] p_lat;
    logic [PERIOD_W-1:0] p_lat_n;
    logic [COUNT_W-1:0]  n_lat;
    logic [COUNT_W-1:0]  n_lat_n;
    logic [COUNT_W-1:0]  pulse_count_n;
    logic                pulse_n;
    logic                busy_n;
    logic                done_n;

    // Two-flop synchroniser, debounce counter and rising-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            deb_d <= deb;
            if (s2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb     <= s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DCNT_W'(1);
            end
        end
    end

    assign trig = deb & ~deb_d;

    // Burst FSM state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ival        <= '0;
            p_lat       <= '0;
            n_lat       <= '0;
            pulse_count <= '0;
            pulse       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            ival        <= ival_n;
            p_lat       <= p_lat_n;
            n_lat       <= n_lat_n;
            pulse_count <= pulse_count_n;
            pulse       <= pulse_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // Completion is taken in the cycle the Nth pulse is visible; abort overrides everything in RUN
    always_comb begin
        state_n       = state;
        ival_n        = ival;
        p_lat_n       = p_lat;
        n_lat_n       = n_lat;
        pulse_count_n = pulse_count;
        pulse_n       = 1'b0;
        busy_n        = busy;
        done_n        = 1'b0;

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (trig && !abort && (burst_len != '0)) begin
                    state_n       = RUN;
                    p_lat_n       = (period == '0) ? PERIOD_W'(1) : period;
                    n_lat_n       = burst_len;
                    ival_n        = PERIOD_W'(1);
                    pulse_count_n = COUNT_W'(1);
                    pulse_n       = 1'b1;
                    busy_n        = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (pulse && (pulse_count == n_lat)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (ival == p_lat) begin
                    ival_n        = PERIOD_W'(1);
                    pulse_n       = 1'b1;
                    pulse_count_n = pulse_count + COUNT_W'(1);
                end else begin
                    ival_n = ival + PERIOD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule
